// File: rtl/euler_step_driver.sv
// ============================================================================
// Module      : euler_step_driver
// Description : Host-side sequencer that repeats Euler steps on the step
//               engine until simulated time reaches t_end. Optional
//               step-halving retry on engine error via macro STEP_HALVE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module euler_step_driver #(
    parameter int DATA_SIZE = 16,
    parameter int CNT_SIZE  = 16,
    parameter int TIMEOUT   = 1024,
    parameter int MAX_RETRY = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic [DATA_SIZE-1:0] t_end,
    input  logic [DATA_SIZE-1:0] h_init,
    output logic                 start,
    output logic [DATA_SIZE-1:0] h_step,
    input  logic                 finish,
    input  logic                 error,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [1:0]           fail_code,
    output logic [DATA_SIZE-1:0] t_now,
    output logic [CNT_SIZE-1:0]  step_count
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_FAIL   = 3'd6;

    localparam logic [1:0] FC_ERROR     = 2'd1;
    localparam logic [1:0] FC_TIMEOUT   = 2'd2;
    localparam logic [1:0] FC_UNDERFLOW = 2'd3;

    logic [2:0]           r_state;
    logic [DATA_SIZE-1:0] r_t_end;
    logic [TMO_W-1:0]     r_tmo;

    logic [DATA_SIZE:0]   w_sum;
    logic [DATA_SIZE-1:0] w_t_next;
    logic                 w_tmo_hit;

    // Saturating time accumulation: a carry out clamps to all-ones.
    assign w_sum     = {1'b0, t_now} + {1'b0, h_step};
    assign w_t_next  = w_sum[DATA_SIZE] ? {DATA_SIZE{1'b1}} : w_sum[DATA_SIZE-1:0];
    assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT - 1));

`ifdef STEP_HALVE_EN
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [RTY_W-1:0]     r_retry;
    logic [DATA_SIZE-1:0] w_h_half;
    logic                 w_can_retry;

    assign w_h_half    = h_step >> 1;
    assign w_can_retry = (r_retry < RTY_W'(MAX_RETRY)) && (w_h_half != '0);
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (MAX_RETRY > 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_t_end    <= '0;
            r_tmo      <= '0;
            start      <= 1'b0;
            h_step     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            fail_code  <= '0;
            t_now      <= '0;
            step_count <= '0;
`ifdef STEP_HALVE_EN
            r_retry    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (go) begin
                        r_t_end    <= t_end;
                        h_step     <= h_init;
                        t_now      <= '0;
                        step_count <= '0;
                        fail_code  <= '0;
                        done       <= 1'b0;
                        fail       <= 1'b0;
`ifdef STEP_HALVE_EN
                        r_retry    <= '0;
`endif
                        if (t_end == '0) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            r_state <= S_ISSUE;
                            start   <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                end

                S_ISSUE: begin
                    start   <= 1'b0;
                    r_tmo   <= '0;
                    r_state <= S_DRAIN;
                end

                // Flush the finish level left over from the previous step.
                S_DRAIN: begin
                    r_tmo <= r_tmo + 1'b1;
                    if (w_tmo_hit) begin
                        r_state   <= S_FAIL;
                        fail      <= 1'b1;
                        fail_code <= FC_TIMEOUT;
                        busy      <= 1'b0;
                    end else if (!finish) begin
                        r_state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    r_tmo <= r_tmo + 1'b1;
                    if (finish) begin
                        if (!error) begin
                            r_state <= S_UPDATE;
                        end else begin
`ifdef STEP_HALVE_EN
                            if (w_can_retry) begin
                                h_step  <= w_h_half;
                                r_retry <= r_retry + 1'b1;
                                r_state <= S_ISSUE;
                                start   <= 1'b1;
                            end else begin
                                r_state   <= S_FAIL;
                                fail      <= 1'b1;
                                busy      <= 1'b0;
                                fail_code <= (w_h_half == '0) ? FC_UNDERFLOW : FC_ERROR;
                            end
`else
                            r_state   <= S_FAIL;
                            fail      <= 1'b1;
                            busy      <= 1'b0;
                            fail_code <= FC_ERROR;
`endif
                        end
                    end else if (w_tmo_hit) begin
                        r_state   <= S_FAIL;
                        fail      <= 1'b1;
                        fail_code <= FC_TIMEOUT;
                        busy      <= 1'b0;
                    end
                end

                S_UPDATE: begin
                    t_now <= w_t_next;
                    if (step_count != {CNT_SIZE{1'b1}}) begin
                        step_count <= step_count + 1'b1;
                    end
`ifdef STEP_HALVE_EN
                    r_retry <= '0;
`endif
                    if (w_t_next >= r_t_end) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        r_state <= S_ISSUE;
                        start   <= 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    start   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_euler_step_driver.sv
// ============================================================================
// Module      : tb_euler_step_driver
// Description : Directed self-checking bench for euler_step_driver with a
//               small behavioural step-engine model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_euler_step_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0;
    logic [15:0] t_end = '0;
    logic [15:0] h_init = '0;
    logic        start;
    logic [15:0] h_step;
    logic        finish;
    logic        error;
    logic        busy;
    logic        done;
    logic        fail;
    logic [1:0]  fail_code;
    logic [15:0] t_now;
    logic [15:0] step_count;

    int n_vec = 0;
    int n_err = 0;

    // Engine model knobs, written only by the stimulus tasks.
    bit eng_en = 1'b1;
    int eng_lat = 5;
    int eng_err_step = 0;
    bit eng_err_always = 1'b0;
    bit stale_req = 1'b0;

    int pend = 0;
    int cnt = 0;
    int nfin = 0;
    int nstart = 0;

    always #5 clk = ~clk;

    euler_step_driver dut (
        .clk        (clk),
        .rst        (rst),
        .go         (go),
        .t_end      (t_end),
        .h_init     (h_init),
        .start      (start),
        .h_step     (h_step),
        .finish     (finish),
        .error      (error),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .fail_code  (fail_code),
        .t_now      (t_now),
        .step_count (step_count)
    );

    // Engine: clears finish on start, raises it eng_lat edges later.
    always @(posedge clk) begin
        if (rst) begin
            finish <= 1'b0;
            error  <= 1'b0;
            pend   <= 0;
            nfin   <= 0;
        end else if (stale_req) begin
            finish <= 1'b1;
            error  <= 1'b0;
        end else if (start) begin
            finish <= 1'b0;
            error  <= 1'b0;
            pend   <= 1;
            cnt    <= eng_lat;
        end else if (pend != 0) begin
            if (cnt == 1) begin
                pend <= 0;
                if (eng_en) begin
                    finish <= 1'b1;
                    error  <= eng_err_always || ((nfin + 1) == eng_err_step);
                    nfin   <= nfin + 1;
                end
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (start) nstart <= nstart + 1;
    end

    task automatic apply_reset();
        eng_en = 1'b1; eng_lat = 5; eng_err_step = 0; eng_err_always = 1'b0;
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_go(input logic [15:0] te, input logic [15:0] hi);
        @(negedge clk);
        t_end = te; h_init = hi; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_end(input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (done || fail) begin
                cycles = i;
                break;
            end
        end
        n_vec++;
        if (cycles < 0) begin
            n_err++;
            $display("FAIL wait_end: no done/fail within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_vec++; if (start !== 1'b0)      begin n_err++; $display("FAIL rst_start: got %0b exp 0", start); end
        n_vec++; if (h_step !== 16'h0)    begin n_err++; $display("FAIL rst_h_step: got %0h exp 0", h_step); end
        n_vec++; if ({busy, done, fail} !== 3'b000) begin n_err++; $display("FAIL rst_flags: got %b exp 000", {busy, done, fail}); end
        n_vec++; if (fail_code !== 2'd0)  begin n_err++; $display("FAIL rst_fail_code: got %0d exp 0", fail_code); end
        n_vec++; if (t_now !== 16'h0)     begin n_err++; $display("FAIL rst_t_now: got %0h exp 0", t_now); end
        n_vec++; if (step_count !== 16'h0) begin n_err++; $display("FAIL rst_step_count: got %0d exp 0", step_count); end
    endtask

    task automatic test_basic();
        int s0, c;
        apply_reset();
        s0 = nstart;
        do_go(16, 4);
        n_vec++; if (start !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL go_to_start: start=%0b busy=%0b exp 1 1", start, busy); end
        repeat (3) @(negedge clk);
        t_end = 0; go = 1'b1;
        @(negedge clk); go = 1'b0;
        n_vec++; if (done !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL go_ignored: done=%0b busy=%0b exp 0 1", done, busy); end
        wait_end(500, c);
        n_vec++; if (nstart - s0 !== 4) begin n_err++; $display("FAIL basic_starts: got %0d exp 4", nstart - s0); end
        n_vec++; if (t_now !== 16'd16)  begin n_err++; $display("FAIL basic_t_now: got %0d exp 16", t_now); end
        n_vec++; if (step_count !== 16'd4) begin n_err++; $display("FAIL basic_count: got %0d exp 4", step_count); end
        n_vec++; if ({done, fail, busy} !== 3'b100) begin n_err++; $display("FAIL basic_flags: got %b exp 100", {done, fail, busy}); end
    endtask

    task automatic test_overshoot();
        int c;
        apply_reset();
        do_go(12, 5);
        wait_end(500, c);
        n_vec++; if (step_count !== 16'd3) begin n_err++; $display("FAIL over_count: got %0d exp 3", step_count); end
        n_vec++; if (t_now !== 16'd15)  begin n_err++; $display("FAIL over_t_now: got %0d exp 15", t_now); end
        n_vec++; if (done !== 1'b1)     begin n_err++; $display("FAIL over_done: got %0b exp 1", done); end
    endtask

    task automatic test_zero_end();
        int s0;
        s0 = nstart;
        do_go(0, 4);
        n_vec++; if ({done, busy, start} !== 3'b100) begin n_err++; $display("FAIL zero_flags: got %b exp 100", {done, busy, start}); end
        n_vec++; if (step_count !== 16'd0 || t_now !== 16'd0) begin n_err++; $display("FAIL zero_state: count=%0d t=%0d exp 0 0", step_count, t_now); end
        repeat (5) @(negedge clk);
        n_vec++; if (nstart !== s0) begin n_err++; $display("FAIL zero_no_start: got %0d starts exp 0", nstart - s0); end
    endtask

    task automatic test_timeout();
        int c;
        apply_reset();
        eng_en = 1'b0;
        do_go(16, 4);
        wait_end(2000, c);
        n_vec++; if (c !== 1025) begin n_err++; $display("FAIL tmo_latency: got %0d exp 1025", c); end
        n_vec++; if (fail !== 1'b1 || fail_code !== 2'd2) begin n_err++; $display("FAIL tmo_code: fail=%0b code=%0d exp 1 2", fail, fail_code); end
    endtask

    task automatic test_error();
        int c;
        apply_reset();
        eng_err_step = 2;
`ifdef STEP_HALVE_EN
        do_go(16, 8);
        wait_end(500, c);
        n_vec++; if (h_step !== 16'd4) begin n_err++; $display("FAIL halve_h: got %0d exp 4", h_step); end
        n_vec++; if (done !== 1'b1 || t_now !== 16'd16 || step_count !== 16'd3) begin n_err++; $display("FAIL halve_run: done=%0b t=%0d count=%0d exp 1 16 3", done, t_now, step_count); end
        apply_reset();
        eng_err_always = 1'b1;
        do_go(16, 1);
        wait_end(500, c);
        n_vec++; if (fail !== 1'b1 || fail_code !== 2'd3) begin n_err++; $display("FAIL underflow: fail=%0b code=%0d exp 1 3", fail, fail_code); end
`else
        do_go(16, 4);
        wait_end(500, c);
        n_vec++; if (fail !== 1'b1 || fail_code !== 2'd1) begin n_err++; $display("FAIL err_code: fail=%0b code=%0d exp 1 1", fail, fail_code); end
        n_vec++; if (step_count !== 16'd1 || t_now !== 16'd4) begin n_err++; $display("FAIL err_count: count=%0d t=%0d exp 1 4", step_count, t_now); end
        n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL err_flags: done=%0b busy=%0b exp 0 0", done, busy); end
`endif
    endtask

    task automatic test_stale_finish();
        int c;
        apply_reset();
        @(negedge clk); stale_req = 1'b1;
        @(negedge clk); stale_req = 1'b0;
        do_go(4, 4);
        repeat (5) @(negedge clk);
        n_vec++; if (step_count !== 16'd0 || busy !== 1'b1) begin n_err++; $display("FAIL stale_early: count=%0d busy=%0b exp 0 1", step_count, busy); end
        wait_end(500, c);
        n_vec++; if (step_count !== 16'd1 || t_now !== 16'd4 || done !== 1'b1) begin n_err++; $display("FAIL stale_end: count=%0d t=%0d done=%0b exp 1 4 1", step_count, t_now, done); end
    endtask

    task automatic test_reset_midrun();
        apply_reset();
        do_go(16, 4);
        repeat (12) @(negedge clk);
        n_vec++; if (step_count !== 16'd1 || busy !== 1'b1) begin n_err++; $display("FAIL mid_pre: count=%0d busy=%0b exp 1 1", step_count, busy); end
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if ({start, busy, done, fail, fail_code, h_step, t_now, step_count} !== '0) begin n_err++; $display("FAIL mid_rst: h=%0h t=%0h n=%0d busy=%0b start=%0b exp all 0", h_step, t_now, step_count, busy, start); end
        rst = 1'b0;
    endtask

    task automatic test_saturate();
        int c;
        apply_reset();
        do_go(16'hFFFF, 16'hFFF0);
        wait_end(500, c);
        n_vec++; if (t_now !== 16'hFFFF) begin n_err++; $display("FAIL sat_t_now: got %0h exp ffff", t_now); end
        n_vec++; if (done !== 1'b1 || step_count !== 16'd2) begin n_err++; $display("FAIL sat_done: done=%0b count=%0d exp 1 2", done, step_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_end();
        test_overshoot();
        test_timeout();
        test_error();
        test_stale_finish();
        test_reset_midrun();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
